// File: rtl/store_monitor.sv
// store_monitor: watches the CPU data-memory store bus, decides a PASS/FAIL
// verdict in hardware and keeps a show-ahead trace FIFO of sampled stores.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned DEPTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  input  logic        trace_rd,
  output logic        trace_valid,
  output logic [31:0] trace_adr,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0]  TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [AW:0]  FULL_COUNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]  CNT_ZERO     = (AW + 1)'(0);
  localparam logic [AW:0]  CNT_ONE      = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_BADADR  = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;

  logic [1:0]  r_state;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic [1:0]  r_fail_code;
  logic [15:0] r_store_count;
  logic [31:0] r_cycle_count;
  logic        r_overflow;

  logic [31:0]   r_mem_adr  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_store;
  logic        w_is_pass;
  logic        w_is_bad;
  logic        w_timeout;
  logic [1:0]  w_next_state;
  logic [1:0]  w_next_code;
  logic        w_trace_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_drop;
  logic [AW:0] w_next_count;

  // Classify the current edge: is there a store, and does it decide the verdict.
  always_comb begin
    // An unknown strobe must never count as a store.
    w_store   = (mem_write === 1'b1) && (r_state == ST_RUN);
    w_is_pass = w_store && (data_adr == PASS_ADDR) && (write_data == PASS_DATA);
    w_is_bad  = w_store && !w_is_pass && (data_adr != SCRATCH_ADDR);
    w_timeout = (r_state == ST_RUN) && (r_cycle_count == TIMEOUT_LAST);
  end

  // Next verdict state; a deciding store takes priority over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fail_code;
    if (r_state == ST_RUN) begin
      if (w_is_pass) begin
        w_next_state = ST_PASS;
        w_next_code  = CODE_NONE;
      end else if (w_is_bad) begin
        w_next_state = ST_FAIL;
        w_next_code  = CODE_BADADR;
      end else if (w_timeout) begin
        w_next_state = ST_FAIL;
        w_next_code  = CODE_TIMEOUT;
      end else begin
        w_next_state = ST_RUN;
      end
    end else begin
      w_next_state = r_state;
    end
  end

  // Trace FIFO handshake: a pop frees the slot a same-edge push needs when full.
  always_comb begin
    w_trace_valid = (r_count != CNT_ZERO);
    w_full        = (r_count == FULL_COUNT);
    w_pop         = trace_rd && w_trace_valid;
    w_push_ok     = w_store && (!w_full || w_pop);
    w_drop        = w_store && w_full && !w_pop;
    case ({w_push_ok, w_pop})
      2'b10:   w_next_count = r_count + CNT_ONE;
      2'b01:   w_next_count = r_count - CNT_ONE;
      default: w_next_count = r_count;
    endcase
  end

  // Verdict state, registered verdict outputs and run counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_code   <= CODE_NONE;
      r_store_count <= 16'd0;
      r_cycle_count <= 32'd0;
    end else begin
      r_state     <= w_next_state;
      r_done      <= (w_next_state != ST_RUN);
      r_pass      <= (w_next_state == ST_PASS);
      r_fail      <= (w_next_state == ST_FAIL);
      r_fail_code <= w_next_code;
      if (r_state == ST_RUN) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_store && (r_store_count != 16'hFFFF)) begin
        r_store_count <= r_store_count + 16'd1;
      end
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_count    <= CNT_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= w_next_count;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_adr[r_wptr]  <= data_adr;
      r_mem_data[r_wptr] <= write_data;
    end
  end

  assign trace_valid    = w_trace_valid;
  assign trace_adr      = r_mem_adr[r_rptr];
  assign trace_data     = r_mem_data[r_rptr];
  assign trace_overflow = r_overflow;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign fail_code      = r_fail_code;
  assign store_count    = r_store_count;
  assign cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_store_monitor.sv
// Directed self-checking bench for store_monitor (TIMEOUT=20, DEPTH=8).
module tb_store_monitor;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        trace_rd;
  logic        trace_valid;
  logic [31:0] trace_adr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [15:0] store_count;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;

  store_monitor #(
    .PASS_ADDR   (32'd100),
    .PASS_DATA   (32'd25),
    .SCRATCH_ADDR(32'd96),
    .TIMEOUT     (20),
    .DEPTH       (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_write     (mem_write),
    .data_adr      (data_adr),
    .write_data    (write_data),
    .trace_rd      (trace_rd),
    .trace_valid   (trace_valid),
    .trace_adr     (trace_adr),
    .trace_data    (trace_data),
    .trace_overflow(trace_overflow),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code),
    .store_count   (store_count),
    .cycle_count   (cycle_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one posedge and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_write = 1'b0; trace_rd = 1'b0;
    data_adr = 32'd0; write_data = 32'd0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    mem_write = 1'b1; data_adr = adr; write_data = dat;
    step();
    mem_write = 1'b0;
  endtask

  initial begin
    int expd [8];
    expd = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd11};

    // Reset state and PASS path with drain.
    do_reset();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, trace_valid}, 32'd0);
    chk("rst_scnt", {16'd0, store_count}, 32'd0);
    chk("rst_ccnt", cycle_count, 32'd0);
    chk("rst_code", {30'd0, fail_code}, 32'd0);
    store(32'd96, 32'd7);
    chk("scratch_done", {31'd0, done}, 32'd0);
    store(32'd100, 32'd25);
    chk("p_pass", {31'd0, pass}, 32'd1);
    chk("p_fail", {31'd0, fail}, 32'd0);
    chk("p_done", {31'd0, done}, 32'd1);
    chk("p_code", {30'd0, fail_code}, 32'd0);
    chk("p_scnt", {16'd0, store_count}, 32'd2);
    chk("p_ccnt", cycle_count, 32'd2);
    chk("p_h0_valid", {31'd0, trace_valid}, 32'd1);
    chk("p_h0_adr", trace_adr, 32'd96);
    chk("p_h0_data", trace_data, 32'd7);
    trace_rd = 1'b1;
    step();
    chk("p_h1_adr", trace_adr, 32'd100);
    chk("p_h1_data", trace_data, 32'd25);
    step();
    chk("p_empty", {31'd0, trace_valid}, 32'd0);
    step();
    trace_rd = 1'b0;
    chk("p_empty_rd", {31'd0, trace_valid}, 32'd0);
    chk("p_ccnt_hold", cycle_count, 32'd2);

    // Wrong data at PASS_ADDR fails; later stores are ignored.
    do_reset();
    store(32'd100, 32'd24);
    chk("w_fail", {31'd0, fail}, 32'd1);
    chk("w_code", {30'd0, fail_code}, 32'd1);
    store(32'd100, 32'd25);
    chk("w_pass", {31'd0, pass}, 32'd0);
    chk("w_scnt", {16'd0, store_count}, 32'd1);
    chk("w_head", trace_data, 32'd24);
    trace_rd = 1'b1;
    step();
    trace_rd = 1'b0;
    chk("w_one_entry", {31'd0, trace_valid}, 32'd0);

    // Scratch store then a bad address.
    do_reset();
    store(32'h60, 32'd3);
    chk("b_run", {31'd0, done}, 32'd0);
    store(32'h64, 32'd3);
    chk("b_fail", {31'd0, fail}, 32'd1);
    chk("b_code", {30'd0, fail_code}, 32'd1);
    chk("b_ccnt", cycle_count, 32'd2);
    step();
    step();
    chk("b_ccnt_frozen", cycle_count, 32'd2);

    // Timeout with no stores.
    do_reset();
    for (int i = 0; i < 19; i++) step();
    chk("t_pre_done", {31'd0, done}, 32'd0);
    chk("t_pre_ccnt", cycle_count, 32'd19);
    step();
    chk("t_fail", {31'd0, fail}, 32'd1);
    chk("t_code", {30'd0, fail_code}, 32'd2);
    chk("t_ccnt", cycle_count, 32'd20);

    // Pass store on the timeout edge wins.
    do_reset();
    for (int i = 0; i < 19; i++) step();
    store(32'd100, 32'd25);
    chk("tp_pass", {31'd0, pass}, 32'd1);
    chk("tp_fail", {31'd0, fail}, 32'd0);
    chk("tp_code", {30'd0, fail_code}, 32'd0);
    chk("tp_ccnt", cycle_count, 32'd20);

    // Overflow, simultaneous push/pop when full, wrap-around drain.
    do_reset();
    for (int i = 1; i <= 10; i++) store(32'd96, 32'(i));
    chk("o_ovf", {31'd0, trace_overflow}, 32'd1);
    chk("o_scnt", {16'd0, store_count}, 32'd10);
    chk("o_head", trace_data, 32'd1);
    trace_rd = 1'b1;
    store(32'd96, 32'd11);
    chk("o_scnt2", {16'd0, store_count}, 32'd11);
    for (int i = 0; i < 8; i++) begin
      chk("o_drain_valid", {31'd0, trace_valid}, 32'd1);
      chk("o_drain_adr", trace_adr, 32'd96);
      chk("o_drain_data", trace_data, 32'(expd[i]));
      step();
    end
    trace_rd = 1'b0;
    chk("o_drained", {31'd0, trace_valid}, 32'd0);
    chk("o_ovf_sticky", {31'd0, trace_overflow}, 32'd1);

    // Reset mid-drain in FAIL, then an unknown strobe.
    do_reset();
    for (int i = 1; i <= 9; i++) store(32'd96, 32'(i));
    store(32'h64, 32'd3);
    chk("r_fail", {31'd0, fail}, 32'd1);
    trace_rd = 1'b1;
    step();
    chk("r_mid_valid", {31'd0, trace_valid}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    trace_rd = 1'b0;
    chk("r_done", {31'd0, done}, 32'd0);
    chk("r_fail_clr", {31'd0, fail}, 32'd0);
    chk("r_valid", {31'd0, trace_valid}, 32'd0);
    chk("r_ovf", {31'd0, trace_overflow}, 32'd0);
    chk("r_scnt", {16'd0, store_count}, 32'd0);
    chk("r_ccnt", cycle_count, 32'd0);
    mem_write = 1'bx; data_adr = 32'd100; write_data = 32'd24;
    step();
    mem_write = 1'b0;
    chk("x_scnt", {16'd0, store_count}, 32'd0);
    chk("x_done", {31'd0, done}, 32'd0);
    chk("x_valid", {31'd0, trace_valid}, 32'd0);
    chk("x_ccnt", cycle_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Sits directly downstream of the single-cycle CPU top and consumes its data-memory store bus: MemWrite, DataAdr, WriteData.
- Decides the program verdict in hardware:
  - PASS on the magic store.
  - FAIL on a store to any non-scratch address, or on watchdog timeout.
- Keeps a small show-ahead trace FIFO of stores so benches and debug logic can drain the store history through a valid/ready-style pop handshake.

Parameters:
- PASS_ADDR, 32'd100, store address that signals completion.
- PASS_DATA, 32'd25, data value required at PASS_ADDR for PASS.
- SCRATCH_ADDR, 32'd96, only address the program may otherwise store to.
- TIMEOUT, 1000, cycles in RUN without a verdict before timeout FAIL; minimum 2.
- DEPTH, 8, trace FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (0 at a posedge clears the block)
- mem_write  in  1  store strobe from CPU top
- data_adr  in  32  store address from CPU top
- write_data  in  32  store data from CPU top
- trace_rd  in  1  pop request for the trace FIFO
- trace_valid  out  1  FIFO non-empty; head entry presented on trace_adr/trace_data
- trace_adr  out  32  address of head entry
- trace_data  out  32  data of head entry
- trace_overflow  out  1  sticky; a store was dropped because the FIFO was full
- done  out  1  verdict reached (PASS or FAIL)
- pass  out  1  verdict is PASS
- fail  out  1  verdict is FAIL
- fail_code  out  2  0 none, 1 bad store address, 2 timeout
- store_count  out  16  stores seen in RUN; saturates at 16'hFFFF
- cycle_count  out  32  cycles spent in RUN; freezes at verdict

Behaviour:
- Reset (reset==0 at posedge):
  - state=RUN; all outputs 0; FIFO empty.
  - Reset dominates every other event, including mid-drain and post-verdict.
- States:
  - RUN: monitor active.
  - PASS, FAIL: terminal; left only by reset.
- Store sampling: a store is mem_write===1 at a posedge while state==RUN. X/Z on mem_write is not a store.
- RUN transitions, evaluated at each posedge; verdict outputs are registered, visible 1 cycle after the deciding edge:
  - Store with data_adr==PASS_ADDR && write_data==PASS_DATA -> PASS; fail_code stays 0.
  - Otherwise, store with data_adr!=SCRATCH_ADDR -> FAIL, fail_code=1. A store to PASS_ADDR with wrong data is this case.
  - Store to SCRATCH_ADDR -> stay in RUN.
  - No deciding store and cycle_count==TIMEOUT-1 -> FAIL, fail_code=2.
  - Deciding store on the timeout edge: the store verdict wins over timeout.
- Outputs by state:
  - PASS: done=1, pass=1.
  - FAIL: done=1, fail=1.
  - pass and fail are never 1 together.
- cycle_count: increments each posedge in RUN, including the deciding edge; holds thereafter.
- store_count: increments on every sampled store, including the deciding one; saturating; no increments after the verdict.
- Trace FIFO:
  - Every sampled store pushes {data_adr, write_data}, including the deciding store. Stores after the verdict are not logged.
  - Pop when trace_rd && trace_valid. trace_rd while empty is ignored.
  - Show-ahead: the head is valid combinationally from registers. A push into an empty FIFO sets trace_valid at the next cycle.
  - Push and pop on the same edge:
    - Count unchanged.
    - When full, the push is accepted because the pop frees the slot.
    - When empty, the pop is ignored and the push is accepted.
  - Push while full without pop: entry dropped; trace_overflow=1 until reset.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an occupancy count (0..DEPTH).
  - Drain continues normally in PASS/FAIL.

Test Plan:
- Reset held low 2 cycles, then released; stores to 96 (data 7), then store 100/25 -> pass=1, fail=0, fail_code=0 one cycle after the 100/25 edge; store_count=2; FIFO drains (96,7), then (100,25), then trace_valid=0.
- Store 100/24 -> fail=1, fail_code=1; a later store 100/25 is ignored: pass stays 0, store_count=1, FIFO holds one entry.
- Store to 0x60 then 0x64 (data 3) -> FAIL, fail_code=1 after the 0x64 store; cycle_count frozen.
- No stores, TIMEOUT=20 -> fail=1, fail_code=2 with cycle_count=20. Separate run: store 100/25 on the edge where cycle_count==19 -> PASS, fail_code=0.
- DEPTH=8, 10 stores to 96 with no pops -> trace_overflow=1, 8 entries retained (first 8 data values). Then 1 cycle with simultaneous store and trace_rd while full -> occupancy stays 8, no further overflow effect; drain order is correct across pointer wrap.
- reset driven low mid-drain in FAIL -> next cycle: state RUN, done=0, trace_valid=0, trace_overflow=0, counts 0; mem_write=X for a cycle -> no store counted.
